// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller for an async FIFO (wclk domain).
// Define WFIFO_OVF_CNT_EN to build the sticky overflow flag and saturating attempt counter.
module wptr_full_ctrl #(
  parameter int unsigned ADDR_SIZE    = 8,
  parameter int unsigned AFULL_THRESH = 4
) (
  input  logic                 wclk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rptr_gray,
  output logic                 wclken,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr_gray,
  output logic                 wfull,
  output logic                 wafull,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf,
  output logic [7:0]           wovf_cnt,
  input  logic                 wovf_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AFULL_LEVEL = (ADDR_SIZE+1)'(DEPTH - AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wgray_q, wgray_d;
  logic [ADDR_SIZE:0] rq1_q, rq2_q;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] level_d;
  logic [ADDR_SIZE:0] level_q;
  logic               full_d, full_q;
  logic               afull_d, afull_q;

  // Gated by rst_n so nothing reaches the RAM while reset is held.
  assign wclken    = winc & ~full_q & rst_n;
  assign waddr     = wbin_q[ADDR_SIZE-1:0];
  assign wptr_gray = wgray_q;
  assign wfull     = full_q;
  assign wafull    = afull_q;
  assign wlevel    = level_q;

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_SIZE{1'b0}}, wclken};
    wgray_d = wbin_d ^ (wbin_d >> 1);

    rbin = '0;
    rbin[ADDR_SIZE] = rq2_q[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rq2_q[i];
    end

    level_d = wbin_d - rbin;
    // Full when next write pointer is one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rq2_q[ADDR_SIZE:ADDR_SIZE-1], rq2_q[ADDR_SIZE-2:0]});
    afull_d = (level_d >= AFULL_LEVEL);
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
    end
  end

`ifdef WFIFO_OVF_CNT_EN
  logic       ovf_q;
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (wovf_clr) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (winc && full_q) begin
      ovf_q <= 1'b1;
      if (ovf_cnt_q != 8'hff) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  assign wovf     = ovf_q;
  assign wovf_cnt = ovf_cnt_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = wovf_clr;
  assign wovf           = 1'b0;
  assign wovf_cnt       = '0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed, table-driven bench for wptr_full_ctrl at ADDR_SIZE=3, AFULL_THRESH=2.
module tb_wptr_full_ctrl;

  localparam int unsigned AW = 3;
`ifdef WFIFO_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          wclk;
  logic          rst_n;
  logic          winc;
  logic [AW:0]   rptr_gray;
  logic          wclken;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wlevel;
  logic          wovf;
  logic [7:0]    wovf_cnt;
  logic          wovf_clr;

  wptr_full_ctrl #(
    .ADDR_SIZE   (AW),
    .AFULL_THRESH(2)
  ) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .winc     (winc),
    .rptr_gray(rptr_gray),
    .wclken   (wclken),
    .waddr    (waddr),
    .wptr_gray(wptr_gray),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel),
    .wovf     (wovf),
    .wovf_cnt (wovf_cnt),
    .wovf_clr (wovf_clr)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic          winc;
    logic [AW:0]   rptr;
    logic          en;
    logic [AW-1:0] addr;
    logic [AW:0]   gray;
    logic          full;
    logic          afull;
    logic [AW:0]   level;
  } vec_t;

  vec_t vecs [20];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Inputs set just after an edge; combinational outputs checked mid-cycle, registered after edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      winc      = vecs[i].winc;
      rptr_gray = vecs[i].rptr;
      #3;
      chk($sformatf("v%0d wclken", i), {31'd0, wclken}, {31'd0, vecs[i].en});
      chk($sformatf("v%0d waddr", i), {29'd0, waddr}, {29'd0, vecs[i].addr});
      step();
      chk($sformatf("v%0d wptr_gray", i), {28'd0, wptr_gray}, {28'd0, vecs[i].gray});
      chk($sformatf("v%0d wfull", i), {31'd0, wfull}, {31'd0, vecs[i].full});
      chk($sformatf("v%0d wafull", i), {31'd0, wafull}, {31'd0, vecs[i].afull});
      chk($sformatf("v%0d wlevel", i), {28'd0, wlevel}, {28'd0, vecs[i].level});
    end
  endtask

  initial begin
    logic [AW:0] wbin_m;
    logic [AW:0] gray_m;
    logic [AW:0] prev_gray;
    logic [AW:0] back2;
    bit          saw_wrap;
    bit          got_full;

    // Fill from empty with reader at 0.
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b1, 4'b0000, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0, 4'd2};
    vecs[2]  = '{1'b1, 4'b0000, 1'b1, 3'd2, 4'b0010, 1'b0, 1'b0, 4'd3};
    vecs[3]  = '{1'b1, 4'b0000, 1'b1, 3'd3, 4'b0110, 1'b0, 1'b0, 4'd4};
    vecs[4]  = '{1'b1, 4'b0000, 1'b1, 3'd4, 4'b0111, 1'b0, 1'b0, 4'd5};
    vecs[5]  = '{1'b1, 4'b0000, 1'b1, 3'd5, 4'b0101, 1'b0, 1'b1, 4'd6};
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, 3'd6, 4'b0100, 1'b0, 1'b1, 4'd7};
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 3'd7, 4'b1100, 1'b1, 1'b1, 4'd8};
    // Writes attempted while full are dropped.
    for (int i = 8; i <= 12; i++) begin
      vecs[i] = '{1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8};
    end
    // Reader frees one slot in the same cycle as a blocked write.
    vecs[13] = '{1'b1, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8};
    vecs[14] = '{1'b1, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8};
    vecs[15] = '{1'b1, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7};
    vecs[16] = '{1'b1, 4'b0001, 1'b1, 3'd0, 4'b1101, 1'b1, 1'b1, 4'd8};
    // Reader jumps to bin 4: release seen two edges later.
    vecs[17] = '{1'b0, 4'b0110, 1'b0, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8};
    vecs[18] = '{1'b0, 4'b0110, 1'b0, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8};
    vecs[19] = '{1'b0, 4'b0110, 1'b0, 3'd1, 4'b1101, 1'b0, 1'b0, 4'd5};

    // Reset held with a write request pending.
    rst_n     = 1'b0;
    winc      = 1'b1;
    rptr_gray = '0;
    wovf_clr  = 1'b0;
    repeat (3) step();
    chk("rst wclken", {31'd0, wclken}, 32'd0);
    chk("rst waddr", {29'd0, waddr}, 32'd0);
    chk("rst wptr_gray", {28'd0, wptr_gray}, 32'd0);
    chk("rst wfull", {31'd0, wfull}, 32'd0);
    chk("rst wafull", {31'd0, wafull}, 32'd0);
    chk("rst wlevel", {28'd0, wlevel}, 32'd0);
    chk("rst wovf", {31'd0, wovf}, 32'd0);
    chk("rst wovf_cnt", {24'd0, wovf_cnt}, 32'd0);
    rst_n = 1'b1;

    run_vecs(0, 12);
    chk("ovf set", {31'd0, wovf}, {31'd0, OVF_EN});
    chk("ovf cnt 5", {24'd0, wovf_cnt}, OVF_EN ? 32'd5 : 32'd0);

    // Clear wins over a same-cycle overflow attempt.
    winc     = 1'b1;
    wovf_clr = 1'b1;
    step();
    wovf_clr = 1'b0;
    chk("ovf clr flag", {31'd0, wovf}, 32'd0);
    chk("ovf clr cnt", {24'd0, wovf_cnt}, 32'd0);

    run_vecs(13, 16);
    chk("ovf cnt 3", {24'd0, wovf_cnt}, OVF_EN ? 32'd3 : 32'd0);
    run_vecs(17, 19);

    // Streaming with the reader two cycles behind; wraps through 15 -> 0.
    wbin_m    = 4'd9;
    prev_gray = wptr_gray;
    saw_wrap  = 1'b0;
    winc      = 1'b1;
    for (int k = 0; k < 20; k++) begin
      back2     = wbin_m - 4'd2;
      rptr_gray = back2 ^ (back2 >> 1);
      #3;
      chk($sformatf("s%0d wclken", k), {31'd0, wclken}, 32'd1);
      chk($sformatf("s%0d waddr", k), {29'd0, waddr}, {29'd0, wbin_m[AW-1:0]});
      step();
      wbin_m = wbin_m + 4'd1;
      gray_m = wbin_m ^ (wbin_m >> 1);
      chk($sformatf("s%0d wptr_gray", k), {28'd0, wptr_gray}, {28'd0, gray_m});
      chk($sformatf("s%0d one bit", k), $countones(prev_gray ^ wptr_gray), 32'd1);
      chk($sformatf("s%0d wfull", k), {31'd0, wfull}, 32'd0);
      if (prev_gray == 4'b1000 && wptr_gray == 4'b0000) saw_wrap = 1'b1;
      prev_gray = wptr_gray;
    end
    chk("wrap seen", {31'd0, saw_wrap}, 32'd1);

    // Fill again, then reset asynchronously mid-cycle.
    got_full = 1'b0;
    for (int k = 0; k < 12 && !got_full; k++) begin
      step();
      if (wfull) got_full = 1'b1;
    end
    chk("refill full", {31'd0, got_full}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wfull", {31'd0, wfull}, 32'd0);
    chk("async rst wlevel", {28'd0, wlevel}, 32'd0);
    chk("async rst wptr_gray", {28'd0, wptr_gray}, 32'd0);
    chk("async rst wclken", {31'd0, wclken}, 32'd0);
    #10;
    rst_n = 1'b1;
    winc  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-side controller for the async FIFO; runs in the wclk domain.
- Sits between the producer and the dual-port storage RAM.
- Accepts producer write requests and drives the RAM's write-enable and write address.
- Keeps the Gray-coded write pointer for the read domain, synchronises the read pointer in, and produces full, almost-full and fill level.

Parameters:
ADDR_SIZE, 8, RAM address width; FIFO depth DEPTH = 2^ADDR_SIZE
AFULL_THRESH, 4, wafull asserts when free slots <= AFULL_THRESH; legal range 1..DEPTH-1

Ports:
wclk  input  1  write-domain clock
rst_n  input  1  reset: asynchronous, active-low
winc  input  1  producer write request, one word per cycle
rptr_gray  input  ADDR_SIZE+1  read pointer from the read domain, Gray-coded, unsynchronised
wclken  output  1  RAM write enable
waddr  output  ADDR_SIZE  RAM write address
wptr_gray  output  ADDR_SIZE+1  registered Gray write pointer, to the read-domain synchroniser
wfull  output  1  FIFO full, registered
wafull  output  1  almost full, registered
wlevel  output  ADDR_SIZE+1  fill level as seen from the write domain, registered
wovf  output  1  sticky overflow flag (see Optional Feature)
wovf_cnt  output  8  overflow attempt count (see Optional Feature)
wovf_clr  input  1  clears wovf and wovf_cnt (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): wbin=0, wptr_gray=0, sync flops rq1=rq2=0, wfull=0, wafull=0, wlevel=0, wovf=0, wovf_cnt=0.
- Reset consequences: wclken=0 and waddr=0.
- Write accept (combinational): wclken = winc & ~wfull.
- Write address (combinational): waddr = wbin[ADDR_SIZE-1:0]. The RAM captures wdata at the same wclk edge.
- Next binary pointer: wbin_next = wbin + wclken, modulo 2^(ADDR_SIZE+1). Wraps naturally.
- Next Gray pointer: wgray_next = wbin_next ^ (wbin_next >> 1).
- Pointer registers: wbin and wptr_gray are registered on every wclk edge. wptr_gray is glitch-free: only one bit changes per increment.
- Read-pointer synchroniser: two flops, rq1 <= rptr_gray, then rq2 <= rq1. Only rq2 is used downstream.
- wfull computation: wfull <= (wgray_next == {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]}).
- Read-pointer conversion: rbin = Gray-to-binary of rq2, by prefix XOR from the MSB down.
- Level arithmetic: wlevel <= (wbin_next - rbin) mod 2^(ADDR_SIZE+1). Range 0..DEPTH.
- wafull rule: wafull <= ((wbin_next - rbin) mod 2^(ADDR_SIZE+1)) >= DEPTH - AFULL_THRESH.
- Latency: a write accepted at edge N is visible on wptr_gray, wfull, wafull and wlevel after edge N. The last write raises wfull at that same edge.
- Read-side release latency: a rptr_gray change before edge N reaches rq2 at edge N+1. wfull/wlevel reflect it after edge N+2.
- Pessimism: wfull and wafull are pessimistic by design. They may stay high up to 3 cycles after space frees; they never under-report.
- Full + winc: request dropped; wclken=0; no pointer change; no RAM write.
- Simultaneous free and write while full: the write is still blocked that cycle; it is accepted once wfull deasserts.
- Reset mid-burst: all state clears immediately, regardless of clock.
- rptr_gray requirement: must come from a register in the read domain. It may change asynchronously to wclk.

Optional Feature:
Macro WFIFO_OVF_CNT_EN.
- Defined:
  - wovf sets on any cycle with winc & wfull and stays set.
  - wovf_cnt increments on the same condition and saturates at 255.
  - wovf_clr (wclk domain) clears both. Clear has priority over a same-cycle set/increment.
- Undefined: wovf and wovf_cnt are tied to 0; wovf_clr is ignored; no counter logic is synthesised.
- Ports are present in both builds.

Test Plan (ADDR_SIZE=3, DEPTH=8, AFULL_THRESH=2):
1. Assert rst_n low for 3 cycles, winc=1 -> wclken=0, waddr=0, wptr_gray=0, wfull=0, wafull=0, wlevel=0. Also pulse rst_n low mid-cycle while full -> wfull clears immediately.
2. rptr_gray=0, winc=1 for 8 cycles -> waddr steps 0..7. wafull rises after the 6th accepted write (wlevel=6). wfull rises after the 8th (wlevel=8, wptr_gray=4'b1100).
3. FIFO full, winc=1 for 5 cycles -> wclken=0, wbin stays 8. With WFIFO_OVF_CNT_EN: wovf=1, wovf_cnt=5. Then wovf_clr=1 -> both 0.
4. FIFO full, set rptr_gray=4'b0010 (bin 3) before edge N -> wfull=0 and wlevel=5 after edge N+2; wafull=0.
5. Continuous writes with rptr_gray tracking wptr_gray two cycles later, for 20 writes -> wbin wraps 15->0 (wptr_gray 1000->0000). Each step changes exactly one wptr_gray bit; wfull never asserts.
6. FIFO full, winc=1, rptr_gray advanced in the same cycle -> no write that cycle. The first accepted write lands at waddr=0 exactly one edge after wfull falls.
